bp_be_branch_resolve: RTL and testbench
=======================================

Name: bp_be_branch_resolve

Overview:
- Sits directly downstream of the integer pipe's branch-target output, in the execute stage.
- Tracks the architecturally expected next PC and compares each executed instruction's computed next PC against the frontend's prediction.
- On a mispredict: marks wrong-path instructions as poisoned, issues a one-cycle flush, and sends a redirect command to the frontend over a valid/ready handshake.
- Also maintains a saturating mispredict counter.

Parameters:
- vaddr_width_p, 39: virtual address width of all PC fields.
- boot_pc_p, 39'h0_0010_0000: expected PC after reset.
- ctr_width_p, 16: width of the mispredict counter.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- ex_v_i  input  1  valid instruction present in execute this cycle.
- ex_pc_i  input  vaddr_width_p  PC of the executing instruction.
- br_tgt_i  input  vaddr_width_p  computed next PC from the integer pipe (taken target or pc+4).
- npc_pred_i  input  vaddr_width_p  next PC predicted by the frontend for this instruction.
- commit_v_o  output  1  registered; previous-cycle instruction was on-path.
- poison_v_o  output  1  registered; previous-cycle instruction was wrong-path and must be discarded.
- flush_o  output  1  one-cycle pulse on mispredict detection.
- cmd_v_o  output  1  redirect command valid.
- cmd_ready_i  input  1  frontend accepts the redirect command.
- cmd_pc_o  output  vaddr_width_p  redirect target.
- mispredict_cnt_o  output  ctr_width_p  saturating count of mispredicts.

Behaviour:
- Reset (reset_i low, asynchronous): state=e_resume, expected_pc_r=boot_pc_p; commit_v_o, poison_v_o, flush_o, cmd_v_o=0; cmd_pc_o=0; mispredict_cnt_o=0.
- States: e_run, e_redirect, e_resume. All outputs are registered, giving 1-cycle latency from ex_v_i.
- On-path condition: ex_v_i & (ex_pc_i == expected_pc_r), using a full vaddr_width_p compare.
- e_run:
  - On-path instruction: commit_v_o<=1 and expected_pc_r<=br_tgt_i.
  - If additionally br_tgt_i != npc_pred_i (mispredict): flush_o<=1, cmd_v_o<=1, cmd_pc_o<=br_tgt_i, counter increments, next state=e_redirect.
  - ex_v_i with a PC mismatch: poison_v_o<=1, state unchanged, expected_pc_r unchanged.
- e_redirect:
  - cmd_v_o and cmd_pc_o are held stable until cmd_ready_i is seen high.
  - Every ex_v_i instruction is poisoned, regardless of PC.
  - On cmd_v_o & cmd_ready_i: cmd_v_o<=0, next state=e_resume.
  - The instruction arriving in the handshake cycle is still poisoned.
- e_resume:
  - Instructions with ex_pc_i != expected_pc_r are poisoned.
  - The first on-path instruction is handled exactly as in e_run in the same cycle, including its own mispredict check (a new mispredict goes straight to e_redirect). Otherwise next state=e_run.
- commit_v_o and poison_v_o are never both 1. Both are 0 in any cycle following ex_v_i=0.
- flush_o is high for exactly one cycle per mispredict and is never asserted while in e_redirect.
- Counter saturates at all-ones and does not wrap.
- A redirect whose target equals the current expected_pc_r is still issued; it is not suppressed.
- Reset asserted mid-redirect drops cmd_v_o immediately (asynchronous). No handshake completes after reset.

Test Plan:
- Reset release, ex_pc_i=boot_pc_p, br_tgt_i=npc_pred_i=boot_pc_p+4 -> next cycle commit_v_o=1, flush_o=0; state e_run.
- Sequential on-path stream PC 0x100000, 0x100004, 0x100008, each predicted correctly -> three consecutive commit_v_o=1, no poison, counter=0.
- Mispredict: ex_pc_i=0x100008, br_tgt_i=0x100040, npc_pred_i=0x10000C -> next cycle flush_o=1 for one cycle, cmd_v_o=1, cmd_pc_o=0x100040, counter=1. With cmd_ready_i held low for 3 cycles, cmd_v_o/cmd_pc_o stay stable and wrong-path PCs 0x10000C/0x100010 give poison_v_o=1.
- cmd_ready_i=1 -> cmd_v_o=0 next cycle. Subsequent ex_pc_i=0x100014 is poisoned; ex_pc_i=0x100040 gives commit_v_o=1; state returns to e_run.
- Back-to-back: first on-path instruction in e_resume also mispredicts (br_tgt 0x100080 vs pred 0x100044) -> flush_o=1, cmd_pc_o=0x100080, counter=2.
- Counter saturation with ctr_width_p=2: 5 mispredicts -> mispredict_cnt_o=3. Drive reset_i low while cmd_v_o=1 -> cmd_v_o=0 with no clock edge required.

Source files
------------

// File: rtl/bp_be_branch_resolve.sv
// Branch resolution for the execute stage.
// Tracks the architectural next PC, classifies each executing instruction as
// on-path (commit) or wrong-path (poison), and on a mispredict issues a
// one-cycle flush plus a redirect command to the frontend over valid/ready.
// All outputs are registered: results appear one cycle after ex_v_i.

module bp_be_branch_resolve #(
  parameter int unsigned               vaddr_width_p = 39,
  parameter logic [vaddr_width_p-1:0]  boot_pc_p     = vaddr_width_p'(39'h0_0010_0000),
  parameter int unsigned               ctr_width_p   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     ex_v_i,
  input  logic [vaddr_width_p-1:0] ex_pc_i,
  input  logic [vaddr_width_p-1:0] br_tgt_i,
  input  logic [vaddr_width_p-1:0] npc_pred_i,

  output logic                     commit_v_o,
  output logic                     poison_v_o,
  output logic                     flush_o,

  output logic                     cmd_v_o,
  input  logic                     cmd_ready_i,
  output logic [vaddr_width_p-1:0] cmd_pc_o,

  output logic [ctr_width_p-1:0]   mispredict_cnt_o
);

  typedef enum logic [1:0] {
    e_run,
    e_redirect,
    e_resume
  } state_e;

  state_e                   state_q;
  logic [vaddr_width_p-1:0] expected_pc_q;
  logic                     commit_q;
  logic                     poison_q;
  logic                     flush_q;
  logic                     cmd_v_q;
  logic [vaddr_width_p-1:0] cmd_pc_q;
  logic [ctr_width_p-1:0]   cnt_q;

  logic on_path;
  logic mispredict;
  logic cnt_sat;

  // Full-width PC compare against the architecturally expected PC.
  always_comb begin
    on_path    = ex_v_i && (ex_pc_i == expected_pc_q);
    mispredict = on_path && (br_tgt_i != npc_pred_i);
    cnt_sat    = &cnt_q;
  end

  // Resolution FSM with registered outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= e_resume;
      expected_pc_q <= boot_pc_p;
      commit_q      <= 1'b0;
      poison_q      <= 1'b0;
      flush_q       <= 1'b0;
      cmd_v_q       <= 1'b0;
      cmd_pc_q      <= '0;
      cnt_q         <= '0;
    end else begin
      // Per-instruction status and flush are single-cycle pulses.
      commit_q <= 1'b0;
      poison_q <= 1'b0;
      flush_q  <= 1'b0;

      unique case (state_q)
        // Resume behaves like run, except it only leaves once an on-path
        // instruction shows up; wrong-path arrivals keep it waiting.
        e_run, e_resume: begin
          if (ex_v_i) begin
            if (on_path) begin
              commit_q      <= 1'b1;
              expected_pc_q <= br_tgt_i;
              if (mispredict) begin
                flush_q  <= 1'b1;
                cmd_v_q  <= 1'b1;
                // Issued even when equal to the current expected PC.
                cmd_pc_q <= br_tgt_i;
                if (!cnt_sat) begin
                  cnt_q <= cnt_q + ctr_width_p'(1);
                end
                state_q <= e_redirect;
              end else begin
                state_q <= e_run;
              end
            end else begin
              poison_q <= 1'b1;
            end
          end
        end

        // Everything in flight is wrong-path until the frontend takes the
        // redirect, including the instruction in the handshake cycle.
        e_redirect: begin
          poison_q <= ex_v_i;
          if (cmd_v_q && cmd_ready_i) begin
            cmd_v_q <= 1'b0;
            state_q <= e_resume;
          end
        end

        default: begin
          state_q <= e_resume;
          cmd_v_q <= 1'b0;
        end
      endcase
    end
  end

  assign commit_v_o       = commit_q;
  assign poison_v_o       = poison_q;
  assign flush_o          = flush_q;
  assign cmd_v_o          = cmd_v_q;
  assign cmd_pc_o         = cmd_pc_q;
  assign mispredict_cnt_o = cnt_q;

`ifndef SYNTHESIS
  // An instruction is either committed or poisoned, never both.
  commit_poison_excl: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(commit_v_o && poison_v_o));

  // A pending redirect must not change until accepted.
  cmd_hold: assert property (@(posedge clk_i) disable iff (!reset_i)
    (cmd_v_o && !cmd_ready_i) |=> (cmd_v_o && $stable(cmd_pc_o)));

  // Flush only ever accompanies a freshly raised redirect.
  flush_with_cmd: assert property (@(posedge clk_i) disable iff (!reset_i)
    flush_o |-> cmd_v_o);
`endif

endmodule

// File: tb/tb_bp_be_branch_resolve.sv
// Directed bench for bp_be_branch_resolve. A second instance with a 2-bit
// counter shares all inputs to exercise counter saturation.

module tb_bp_be_branch_resolve;

  localparam int unsigned VW = 39;

  logic          clk;
  logic          reset_n;
  logic          ex_v;
  logic [VW-1:0] ex_pc;
  logic [VW-1:0] br_tgt;
  logic [VW-1:0] npc_pred;
  logic          cmd_ready;

  logic          commit_v, poison_v, flush, cmd_v;
  logic [VW-1:0] cmd_pc;
  logic [15:0]   cnt16;

  logic          s_commit_v, s_poison_v, s_flush, s_cmd_v;
  logic [VW-1:0] s_cmd_pc;
  logic [1:0]    cnt2;

  int n_tests;
  int n_fail;

  bp_be_branch_resolve dut (
    .clk_i            (clk),
    .reset_i          (reset_n),
    .ex_v_i           (ex_v),
    .ex_pc_i          (ex_pc),
    .br_tgt_i         (br_tgt),
    .npc_pred_i       (npc_pred),
    .commit_v_o       (commit_v),
    .poison_v_o       (poison_v),
    .flush_o          (flush),
    .cmd_v_o          (cmd_v),
    .cmd_ready_i      (cmd_ready),
    .cmd_pc_o         (cmd_pc),
    .mispredict_cnt_o (cnt16)
  );

  bp_be_branch_resolve #(
    .ctr_width_p (2)
  ) dut_sat (
    .clk_i            (clk),
    .reset_i          (reset_n),
    .ex_v_i           (ex_v),
    .ex_pc_i          (ex_pc),
    .br_tgt_i         (br_tgt),
    .npc_pred_i       (npc_pred),
    .commit_v_o       (s_commit_v),
    .poison_v_o       (s_poison_v),
    .flush_o          (s_flush),
    .cmd_v_o          (s_cmd_v),
    .cmd_ready_i      (cmd_ready),
    .cmd_pc_o         (s_cmd_pc),
    .mispredict_cnt_o (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic c, input logic p, input logic f,
                          input logic cv);
    check({tag, ".commit"}, 64'(commit_v), 64'(c));
    check({tag, ".poison"}, 64'(poison_v), 64'(p));
    check({tag, ".flush"},  64'(flush),    64'(f));
    check({tag, ".cmd_v"},  64'(cmd_v),    64'(cv));
  endtask

  // Apply one cycle of inputs and sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [VW-1:0] pc, input logic [VW-1:0] tgt,
                      input logic [VW-1:0] pred, input logic rdy);
    ex_v      = v;
    ex_pc     = pc;
    br_tgt    = tgt;
    npc_pred  = pred;
    cmd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    ex_v      = 1'b0;
    ex_pc     = '0;
    br_tgt    = '0;
    npc_pred  = '0;
    cmd_ready = 1'b0;

    #1;
    check_st("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.cmd_pc", 64'(cmd_pc), 64'h0);
    check("reset.cnt", 64'(cnt16), 64'h0);

    #11 reset_n = 1'b1;

    // First instruction at boot PC, correctly predicted.
    step(1'b1, 39'h100000, 39'h100004, 39'h100004, 1'b0);
    check_st("boot", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 39'h100004, 39'h100008, 39'h100008, 1'b0);
    check_st("seq1", 1'b1, 1'b0, 1'b0, 1'b0);
    check("seq1.cnt", 64'(cnt16), 64'h0);

    // Mispredict: taken to 0x100040, predicted fall-through.
    step(1'b1, 39'h100008, 39'h100040, 39'h10000C, 1'b0);
    check_st("mp1", 1'b1, 1'b0, 1'b1, 1'b1);
    check("mp1.cmd_pc", 64'(cmd_pc), 64'h100040);
    check("mp1.cnt", 64'(cnt16), 64'h1);
    check("mp1.cnt2", 64'(cnt2), 64'h1);

    // Redirect held; wrong-path instructions poisoned; no further flush.
    step(1'b1, 39'h10000C, 39'h100010, 39'h100010, 1'b0);
    check_st("wp1", 1'b0, 1'b1, 1'b0, 1'b1);
    check("wp1.cmd_pc", 64'(cmd_pc), 64'h100040);
    step(1'b1, 39'h100010, 39'h100014, 39'h100014, 1'b0);
    check_st("wp2", 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 39'h100014, 39'h100018, 39'h100018, 1'b0);
    check_st("idle_rd", 1'b0, 1'b0, 1'b0, 1'b1);
    check("idle_rd.cmd_pc", 64'(cmd_pc), 64'h100040);

    // Handshake cycle: even the target PC is poisoned here.
    step(1'b1, 39'h100040, 39'h100044, 39'h100044, 1'b1);
    check_st("hs1", 1'b0, 1'b1, 1'b0, 1'b0);

    // Resume: stale PC poisoned, then on-path one mispredicts again.
    step(1'b1, 39'h100014, 39'h100018, 39'h100018, 1'b0);
    check_st("res_wp", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 39'h100040, 39'h100080, 39'h100044, 1'b0);
    check_st("mp2", 1'b1, 1'b0, 1'b1, 1'b1);
    check("mp2.cmd_pc", 64'(cmd_pc), 64'h100080);
    check("mp2.cnt", 64'(cnt16), 64'h2);

    // Immediate accept; flush must have dropped.
    step(1'b0, 39'h0, 39'h0, 39'h0, 1'b1);
    check_st("hs2", 1'b0, 1'b0, 1'b0, 1'b0);

    // Resume -> run, then a mismatching PC in run is poisoned, expected PC kept.
    step(1'b1, 39'h100080, 39'h100084, 39'h100084, 1'b0);
    check_st("res_ok", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 39'h100084, 39'h100088, 39'h100088, 1'b0);
    check_st("run_ok", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 39'h200000, 39'h200004, 39'h200004, 1'b0);
    check_st("run_wp", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 39'h100088, 39'h10008C, 39'h10008C, 1'b0);
    check_st("run_ok2", 1'b1, 1'b0, 1'b0, 1'b0);

    // Self-branch: redirect target equals the new expected PC, still issued.
    step(1'b1, 39'h10008C, 39'h10008C, 39'h100090, 1'b0);
    check_st("mp3", 1'b1, 1'b0, 1'b1, 1'b1);
    check("mp3.cmd_pc", 64'(cmd_pc), 64'h10008C);
    check("mp3.cnt2", 64'(cnt2), 64'h3);
    step(1'b0, 39'h0, 39'h0, 39'h0, 1'b1);
    check("hs3.cmd_v", 64'(cmd_v), 64'h0);

    // Two more mispredicts: wide counter keeps counting, narrow one saturates.
    step(1'b1, 39'h10008C, 39'h100100, 39'h100090, 1'b0);
    check("mp4.cnt", 64'(cnt16), 64'h4);
    check("mp4.cnt2", 64'(cnt2), 64'h3);
    step(1'b0, 39'h0, 39'h0, 39'h0, 1'b1);
    step(1'b1, 39'h100100, 39'h100200, 39'h100104, 1'b0);
    check_st("mp5", 1'b1, 1'b0, 1'b1, 1'b1);
    check("mp5.cnt", 64'(cnt16), 64'h5);
    check("mp5.cnt2", 64'(cnt2), 64'h3);

    // Redirect pending; asynchronous reset drops it without a clock edge.
    step(1'b0, 39'h0, 39'h0, 39'h0, 1'b0);
    check("pend.cmd_v", 64'(cmd_v), 64'h1);
    #2 reset_n = 1'b0;
    #1;
    check_st("areset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("areset.cmd_pc", 64'(cmd_pc), 64'h0);
    check("areset.cnt", 64'(cnt16), 64'h0);
    check("areset.cnt2", 64'(cnt2), 64'h0);
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    check("areset_hold.cmd_v", 64'(cmd_v), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
